// File: rtl/lc3b_ret_stack.sv
// lc3b_ret_stack: circular return-address stack; RAS_BYPASS_EN exposes a same-cycle push on top_addr
module lc3b_ret_stack #(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [15:0]      push_addr,
    input  logic             pop,
    input  logic             flush,
    output logic [15:0]      top_addr,
    output logic             top_valid,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic             underflow
);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] tos;
    logic [PTR_W-1:0] tos_m1;
    logic             empty;
    logic             full;
    logic             replace;
    logic [15:0]      reg_top;
    assign tos_m1  = tos - 1'b1;
    assign empty   = count == '0;
    assign full    = count == FULL;
    assign replace = push && pop && !empty;
    assign reg_top = empty ? 16'h0000 : mem[tos_m1];
`ifdef RAS_BYPASS_EN
    assign top_addr  = (push && !flush) ? push_addr : reg_top;
    assign top_valid = (push && !flush) || !empty;
`else
    assign top_addr  = reg_top;
    assign top_valid = !empty;
`endif
    // storage is intentionally not reset; count gates visibility
    always_ff @(posedge clk)
        if (push && !flush) mem[replace ? tos_m1 : tos] <= push_addr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tos       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            tos   <= '0;
            count <= '0;
        end else if (push && !replace) begin
            tos   <= tos + 1'b1;
            count <= full ? count : count + 1'b1;
            if (full) overflow <= 1'b1;
            if (pop) underflow <= 1'b1;
        end else if (pop && !push) begin
            if (empty) underflow <= 1'b1;
            else begin
                tos   <= tos_m1;
                count <= count - 1'b1;
            end
        end
endmodule

// File: doc/lc3b_ret_stack.md
Name: lc3b_ret_stack

Overview:
- Return-address stack for the LC-3b datapath. It is the reverse path of the branch-target adder: it remembers where control must come back to.
- On JSR/JSRR it captures the return PC (the already-incremented PC) as an lc3b_word.
- On RET (JMP R7) it supplies the predicted return target to the PC mux.
- Circular LIFO with depth parameter, saturating occupancy count, sticky error flags and flush for mispredict recovery.

Parameters:
- DEPTH, 8, number of return-address entries; power of two, 2..64.
- PTR_W, $clog2(DEPTH), top-pointer width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- push  in  1  JSR/JSRR retiring; store push_addr.
- push_addr  in  16  return address (lc3b_word, PC+2).
- pop  in  1  RET retiring; consume top entry.
- flush  in  1  discard all entries (pipeline redirect).
- top_addr  out  16  current top-of-stack return target.
- top_valid  out  1  stack non-empty; top_addr meaningful.
- count  out  PTR_W+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky; a push overwrote the oldest entry.
- underflow  out  1  sticky; a pop arrived while empty.

Behaviour:
- Reset (rst_n low, asynchronous): tos pointer=0, count=0, top_valid=0, top_addr=16'h0000, overflow=0, underflow=0. Entry storage is not reset.
- State: entry array mem[DEPTH], pointer tos (index of the next free slot), count register. All update on the rising edge of clk. All outputs derive from registers; no combinational path from inputs to outputs except under RAS_BYPASS_EN.
- top_addr = mem[tos-1 mod DEPTH] when count>0, else 16'h0000. top_valid = (count!=0).
- Priority per cycle: flush > push&pop > push > pop.
- flush: count<=0, tos<=0. Stored entries are left unchanged. Sticky flags are unaffected. push and pop are ignored in that cycle.
- push only: mem[tos]<=push_addr; tos<=tos+1 (wraps modulo DEPTH); count<=min(count+1, DEPTH).
  - If count==DEPTH, the oldest entry is silently overwritten and overflow<=1.
- pop only:
  - If count>0: tos<=tos-1 (wraps), count<=count-1.
  - If count==0: no state change and underflow<=1.
- push & pop same cycle, count>0: top entry replaced, mem[tos-1]<=push_addr. tos and count unchanged. Covers RET immediately followed by JSR retiring together.
- push & pop same cycle, count==0: treated as push only, and underflow<=1.
- Latency: a push is visible on top_addr/top_valid the cycle after the edge that captures it; same for pop.
- Width: addresses are stored unmodified as 16 bits. No alignment check; bit 0 is passed through.
- Sticky flags clear only on rst_n.
- Reset asserted mid-operation forces all reset values immediately, regardless of clk.

Optional Feature:
- Macro RAS_BYPASS_EN.
- Defined: when push=1 and flush=0 in a cycle, top_addr=push_addr and top_valid=1 combinationally in that same cycle. This gives a RET decoded directly behind a JSR zero-cycle visibility.
- Not defined: outputs are purely registered; a push is visible one cycle later.
- State update is identical in both builds.

Test Plan:
- Reset then idle → top_valid=0, count=0, top_addr=16'h0000, overflow=0, underflow=0. Assert rst_n=0 mid-sequence with count=3 → count=0 immediately, without a clock edge.
- Push 16'h3002, 16'h3010, 16'h3020 → count=3, top_addr=16'h3020. Pop three times → top_addr 16'h3010, then 16'h3002, then top_valid=0.
- DEPTH=8, push 16'h1000..16'h1012 (ten entries, step 2) → count=8, overflow=1. Pop eight times → values 16'h1012 down to 16'h1004. Ninth pop → underflow=1, count stays 0.
- count=2 with top 16'h4000, then push=1, pop=1, push_addr=16'h5000 → count=2, top_addr=16'h5000. Pop → the entry beneath is unchanged.
- count=5, flush=1 together with push=1 → count=0, top_valid=0, push ignored, sticky flags unchanged.
- RAS_BYPASS_EN defined, empty stack, push=1 with push_addr=16'h2222 → top_addr=16'h2222, top_valid=1 in the same cycle. Without the macro → top_valid=0 that cycle and 1 the next.
